and3x2_rr_arbiter: RTL and testbench
====================================

Name: and3x2_rr_arbiter

Overview:
- Shares one combinational And3x2 unit (bitwise 3-input AND over 2-bit lanes, O = I0 & I1 & I2) between N_REQ requesters.
- Round-robin arbitration with valid/ready handshakes on both sides; one registered response slot.
- Sits between client logic and the shared mantle logic cell; the And3x2 itself is instantiated inside this block.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 2, operand/result lane width fed to the shared And3 array.
- ID_W, 2, width of the requester index; must equal clog2(N_REQ).

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- ASYNCRESETN  input  1  asynchronous, active-low reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_ready  output  N_REQ  one-hot grant/accept; at most one bit high.
- req_i0  input  N_REQ*WIDTH  operand I0, requester k at bits [k*WIDTH +: WIDTH].
- req_i1  input  N_REQ*WIDTH  operand I1, same packing.
- req_i2  input  N_REQ*WIDTH  operand I2, same packing.
- rsp_valid  output  1  response holds valid data.
- rsp_ready  input  1  consumer accepts response.
- rsp_data  output  WIDTH  registered I0 & I1 & I2 of the granted request.
- rsp_id  output  ID_W  index of the requester that produced rsp_data.

Behaviour:
- Reset (ASYNCRESETN low, asynchronous):
  - rsp_valid=0, rsp_data=0, rsp_id=0, rr_ptr=0, state=EMPTY.
  - req_ready is combinationally 0 while reset is asserted.
- Slot free condition: slot_free = (state==EMPTY) | (rsp_valid & rsp_ready).
- Arbitration (combinational):
  - If slot_free, grant the first requester with req_valid set, searching from rr_ptr upward with wrap-around modulo N_REQ.
  - req_ready[g]=1 for the granted g only; all other bits are 0.
  - If slot not free, req_ready=0.
- Accept: a transfer on requester g is req_valid[g] & req_ready[g].
  - Next edge: rsp_data <= and3(req_i0[g], req_i1[g], req_i2[g]), rsp_id <= g, rsp_valid <= 1.
  - rr_ptr <= (g+1) mod N_REQ.
- Latency: exactly one cycle from accept to rsp_valid.
- Throughput: one request per cycle while rsp_ready is held high.
- FSM:
  - EMPTY --accept--> FULL.
  - FULL --rsp_ready & accept--> FULL, loading the new data (back-to-back).
  - FULL --rsp_ready & no accept--> EMPTY.
  - FULL --!rsp_ready--> FULL; rsp_data and rsp_id are held stable.
- rr_ptr changes only on an accept. With no valid requesters, rr_ptr and the outputs are unchanged.
- Requesters must hold req_valid and operands until accepted. The block never drops a pending request, and starvation is bounded to N_REQ-1 grants.
- rsp_valid must not deassert without rsp_ready (AXI-style stability).
- Reset mid-operation discards any held response; pending requests are re-arbitrated from index 0 after reset release.
- req_valid deasserted before acceptance is a protocol violation; behaviour is undefined, but the block must not lock up.

Optional Feature:
- Macro: AND3X2_ARB_STATS_EN.
- When defined:
  - Adds output port grant_cnt, N_REQ*8 bits: one 8-bit saturating counter per requester, incremented on each accept and held at 255.
  - Counters reset to 0 on ASYNCRESETN.
- When undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Package and3x2_arb_pkg:
  - Localparams for default N_REQ/WIDTH.
  - State encoding typedef (EMPTY=1'b0, FULL=1'b1).
  - STAT_W=8 and STAT_MAX=8'hFF.
- Sub-module rr_pick:
  - Purely combinational round-robin priority picker.
  - Inputs: req vector and ptr. Outputs: one-hot grant and binary index.
  - Reused by later shared-resource arbiters.
- And3x2 is instantiated as the datapath; no other sub-modules.

Test Plan:
- Reset mid-op: rsp_valid=1 held by rsp_ready=0, pulse ASYNCRESETN low -> rsp_valid=0, rsp_data=0, rsp_id=0 immediately; first grant after release goes to lowest valid index.
- Single request: req_valid=4'b0100, req2 operands I0=2'b11, I1=2'b10, I2=2'b11 -> req_ready=4'b0100 in the same cycle; next cycle rsp_valid=1, rsp_data=2'b10, rsp_id=2; rr_ptr=3.
- Fairness: all four requesters valid continuously, rsp_ready=1 -> grant sequence 0,1,2,3,0,... with one response per cycle.
- Backpressure: rsp_ready=0 after first response, req_valid=4'b1111 -> req_ready=0; rsp_data and rsp_id stable for 10 cycles; on rsp_ready=1, the next grant occurs in the same cycle (back-to-back).
- Wrap/sparse: rr_ptr=3, req_valid=4'b0011 -> grant 0, then grant 1, then grant 0.
- AND3X2_ARB_STATS_EN: 300 accepts from requester 1 -> grant_cnt[15:8]=255, others 0; reset clears all counters.

Source files
------------

// File: rtl/and3x2_arb_pkg.sv
// Shared types and constants for the And3x2 round-robin arbiter and its picker.
package and3x2_arb_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int WIDTH_DEF = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_e;

    localparam int         STAT_W   = 8;
    localparam logic [7:0] STAT_MAX = 8'hFF;

endpackage

// File: rtl/And3x2.sv
// Shared combinational cell: bitwise three-input AND over one lane.
module And3x2 #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    output logic [WIDTH-1:0] O
);

    assign O = I0 & I1 & I2;

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick
    import and3x2_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = $clog2(N_REQ_DEF)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  idx
);

    logic found_s;

    // Scan offsets 0..N_REQ-1 from ptr; inner loop keeps every bit index constant.
    always_comb begin
        gnt     = {N_REQ{1'b0}};
        idx     = {ID_W{1'b0}};
        found_s = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!found_s && req[j] && (((int'(ptr) + i) % N_REQ) == j)) begin
                    found_s = 1'b1;
                    gnt[j]  = 1'b1;
                    idx     = ID_W'(j);
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

endmodule

// File: rtl/and3x2_rr_arbiter.sv
// Round-robin arbiter sharing one And3x2 cell between N_REQ requesters, one response slot.
// Optional per-requester grant counters: define AND3X2_ARB_STATS_EN.
module and3x2_rr_arbiter
    import and3x2_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int ID_W  = $clog2(N_REQ_DEF)
) (
    input  logic                   CLK,
    input  logic                   ASYNCRESETN,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_i0,
    input  logic [N_REQ*WIDTH-1:0] req_i1,
    input  logic [N_REQ*WIDTH-1:0] req_i2,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [ID_W-1:0]        rsp_id
`ifdef AND3X2_ARB_STATS_EN
    ,
    output logic [N_REQ*8-1:0]     grant_cnt
`endif
);

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;

    logic             slot_free_s;
    logic             accept_s;
    logic [N_REQ-1:0] pick_gnt_s;
    logic [ID_W-1:0]  pick_idx_s;
    logic [WIDTH-1:0] op0_s, op1_s, op2_s, and_s;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt_s),
        .idx (pick_idx_s)
    );

    And3x2 #(
        .WIDTH (WIDTH)
    ) u_and3 (
        .I0 (op0_s),
        .I1 (op1_s),
        .I2 (op2_s),
        .O  (and_s)
    );

    // Grant only into a free slot; ready is forced low while reset is held.
    always_comb begin
        slot_free_s = (state_q == EMPTY) | rsp_ready;
        if (slot_free_s && ASYNCRESETN) begin
            req_ready = pick_gnt_s;
        end else begin
            req_ready = {N_REQ{1'b0}};
        end
        accept_s = |(req_valid & req_ready);
    end

    // Steer the granted requester's operands into the shared cell.
    always_comb begin
        op0_s = {WIDTH{1'b0}};
        op1_s = {WIDTH{1'b0}};
        op2_s = {WIDTH{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            if (pick_idx_s == ID_W'(k)) begin
                op0_s = req_i0[k*WIDTH +: WIDTH];
                op1_s = req_i1[k*WIDTH +: WIDTH];
                op2_s = req_i2[k*WIDTH +: WIDTH];
            end else begin
                op0_s = op0_s;
            end
        end
    end

    // Slot FSM next state plus response/pointer load on accept.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        case (state_q)
            EMPTY:   state_d = accept_s ? FULL : EMPTY;
            FULL:    state_d = (rsp_ready && !accept_s) ? EMPTY : FULL;
            default: state_d = EMPTY;
        endcase
        if (accept_s) begin
            rsp_data_d = and_s;
            rsp_id_d   = pick_idx_s;
            rr_ptr_d   = (pick_idx_s == ID_W'(N_REQ - 1)) ? {ID_W{1'b0}} : pick_idx_s + ID_W'(1);
        end else begin
            rsp_data_d = rsp_data_q;
        end
    end

    // State, pointer and response registers.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q    <= EMPTY;
            rr_ptr_q   <= {ID_W{1'b0}};
            rsp_data_q <= {WIDTH{1'b0}};
            rsp_id_q   <= {ID_W{1'b0}};
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

`ifdef AND3X2_ARB_STATS_EN
    logic [STAT_W-1:0] grant_cnt_q [N_REQ];
    logic [STAT_W-1:0] grant_cnt_d [N_REQ];

    // Saturating per-requester accept counters.
    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            grant_cnt_d[k] = grant_cnt_q[k];
            if (accept_s && (pick_idx_s == ID_W'(k)) && (grant_cnt_q[k] != STAT_MAX)) begin
                grant_cnt_d[k] = grant_cnt_q[k] + 8'd1;
            end else begin
                grant_cnt_d[k] = grant_cnt_q[k];
            end
        end
    end

    // Counter registers.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            for (int k = 0; k < N_REQ; k++) begin
                grant_cnt_q[k] <= 8'd0;
            end
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                grant_cnt_q[k] <= grant_cnt_d[k];
            end
        end
    end

    // Flatten counters onto the output port.
    always_comb begin
        grant_cnt = {(N_REQ*8){1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            grant_cnt[k*8 +: 8] = grant_cnt_q[k];
        end
    end
`endif

endmodule

// File: tb/tb_and3x2_rr_arbiter.sv
// Directed self-checking bench for and3x2_rr_arbiter (N_REQ=4, WIDTH=2).
`timescale 1ns/100ps
module tb_and3x2_rr_arbiter;

    logic       CLK;
    logic       ASYNCRESETN;
    logic [3:0] req_valid;
    logic [3:0] req_ready;
    logic [7:0] req_i0, req_i1, req_i2;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_data;
    logic [1:0] rsp_id;
`ifdef AND3X2_ARB_STATS_EN
    logic [31:0] grant_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Hand-computed I0 & I1 & I2 per requester for the operand set below.
    logic [1:0] exp_data [4];

    and3x2_rr_arbiter dut (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_i0      (req_i0),
        .req_i1      (req_i1),
        .req_i2      (req_i2),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_id      (rsp_id)
`ifdef AND3X2_ARB_STATS_EN
        ,
        .grant_cnt   (grant_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_checks = n_checks;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        int g;
        // Requester operands: r0 11&01&11=01, r1 10&11&11=10, r2 11&10&11=10, r3 11&11&11=11
        exp_data[0] = 2'b01;
        exp_data[1] = 2'b10;
        exp_data[2] = 2'b10;
        exp_data[3] = 2'b11;
        req_i0      = 8'b11_11_10_11;
        req_i1      = 8'b11_10_11_01;
        req_i2      = 8'b11_11_11_11;
        ASYNCRESETN = 1'b0;
        req_valid   = 4'b1111;
        rsp_ready   = 1'b0;

        @(negedge CLK);
        #1;
        check_val("rst_ready", 32'(req_ready), 32'h0);
        check_val("rst_valid", 32'(rsp_valid), 32'h0);
        check_val("rst_data",  32'(rsp_data),  32'h0);
        check_val("rst_id",    32'(rsp_id),    32'h0);
        @(negedge CLK);
        ASYNCRESETN = 1'b1;

        // Single request from requester 2.
        req_valid = 4'b0100;
        #1;
        check_val("single_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0011;
        rsp_ready = 1'b1;
        #1;
        check_val("single_valid", 32'(rsp_valid), 32'h1);
        check_val("single_data",  32'(rsp_data),  32'h2);
        check_val("single_id",    32'(rsp_id),    32'h2);
        // Pointer sits at 3, so sparse 0011 wraps to requester 0.
        check_val("wrap_ready0", 32'(req_ready), 32'h1);
        tick();
        check_val("wrap_id0",    32'(rsp_id),    32'h0);
        check_val("wrap_data0",  32'(rsp_data),  32'(exp_data[0]));
        check_val("wrap_ready1", 32'(req_ready), 32'h2);
        tick();
        check_val("wrap_id1",    32'(rsp_id),    32'h1);
        check_val("wrap_ready2", 32'(req_ready), 32'h1);
        tick();
        check_val("wrap_id2",    32'(rsp_id),    32'h0);
        req_valid = 4'b0000;
        #1;
        check_val("idle_ready",  32'(req_ready), 32'h0);
        tick();
        check_val("drain_valid", 32'(rsp_valid), 32'h0);
        check_val("drain_id",    32'(rsp_id),    32'h0);

        // Fairness: pointer is 1 after last grant to 0.
        req_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            g = (1 + i) % 4;
            #1;
            check_val("fair_ready", 32'(req_ready), 32'(4'b0001 << g));
            tick();
            check_val("fair_valid", 32'(rsp_valid), 32'h1);
            check_val("fair_id",    32'(rsp_id),    32'(g));
            check_val("fair_data",  32'(rsp_data),  32'(exp_data[g]));
        end

        // Backpressure: last response was requester 0.
        rsp_ready = 1'b0;
        #1;
        check_val("bp_ready", 32'(req_ready), 32'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("bp_valid", 32'(rsp_valid), 32'h1);
            check_val("bp_id",    32'(rsp_id),    32'h0);
            check_val("bp_data",  32'(rsp_data),  32'(exp_data[0]));
        end
        rsp_ready = 1'b1;
        #1;
        check_val("b2b_ready", 32'(req_ready), 32'h2);
        tick();
        check_val("b2b_id",   32'(rsp_id),   32'h1);
        check_val("b2b_data", 32'(rsp_data), 32'(exp_data[1]));

        // Reset mid-operation with a held response.
        rsp_ready = 1'b0;
        #1;
        check_val("mid_pre_valid", 32'(rsp_valid), 32'h1);
        ASYNCRESETN = 1'b0;
        #1;
        check_val("mid_valid", 32'(rsp_valid), 32'h0);
        check_val("mid_data",  32'(rsp_data),  32'h0);
        check_val("mid_id",    32'(rsp_id),    32'h0);
        check_val("mid_ready", 32'(req_ready), 32'h0);
        #1;
        ASYNCRESETN = 1'b1;
        req_valid   = 4'b0110;
        #1;
        check_val("post_rst_ready", 32'(req_ready), 32'h2);
        tick();
        check_val("post_rst_id",   32'(rsp_id),   32'h1);
        check_val("post_rst_data", 32'(rsp_data), 32'(exp_data[1]));

`ifdef AND3X2_ARB_STATS_EN
        ASYNCRESETN = 1'b0;
        #1;
        check_val("cnt_rst0", grant_cnt, 32'h0);
        ASYNCRESETN = 1'b1;
        req_valid   = 4'b0010;
        rsp_ready   = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
        end
        check_val("cnt_sat", grant_cnt, 32'h0000_FF00);
        ASYNCRESETN = 1'b0;
        #1;
        check_val("cnt_rst1", grant_cnt, 32'h0);
        ASYNCRESETN = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
